// File: rtl/uart_sched_pkg.sv
// Shared types and field positions for the UART TX word scheduler.
package uart_sched_pkg;

    localparam int unsigned FIFO_W     = 32;
    localparam int unsigned PAYLOAD_W  = 24;
    localparam int unsigned BYTE_CNT_W = 2;
    localparam int unsigned N_LSB      = 24;
    localparam int unsigned N_MSB      = 25;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned LANES      = 4;
    localparam int unsigned SENT_W     = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_SEND,
        S_WAIT
    } state_t;

    // Payload byte lane for the idx-th transmitted byte of an n-byte word.
    function automatic logic [BYTE_CNT_W-1:0] byte_pos(
        input logic                  msb_first,
        input logic [BYTE_CNT_W-1:0] n,
        input logic [BYTE_CNT_W-1:0] idx
    );
        return msb_first ? BYTE_CNT_W'(n - idx - BYTE_CNT_W'(1)) : idx;
    endfunction

endpackage

// File: rtl/uart_tx_sched.sv
// Fetches length-tagged words from a TX FIFO and hands their bytes to a UART
// transmitter one at a time, honouring the transmitter's busy handshake.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [FIFO_W-1:0] fifo_dout,
    output logic              fifo_rden,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [BYTE_W-1:0] tx_data,
    output logic              busy,
    output logic [SENT_W-1:0] bytes_sent
);

    state_t                      state;
    state_t                      state_nxt;
    logic [PAYLOAD_W-1:0]        payload;
    logic [BYTE_CNT_W-1:0]       nbytes;
    logic [BYTE_CNT_W-1:0]       idx;
    logic [BYTE_CNT_W-1:0]       pos;
    logic [LANES*BYTE_W-1:0]     payload_ext;
    logic [BYTE_W-1:0]           byte_sel;
    logic [BYTE_W-1:0]           tx_data_q;
    logic                        unused_fifo_hi;

    assign unused_fifo_hi = ^fifo_dout[FIFO_W-1:N_MSB+1];

    // Indexed byte mux; the top lane is padding so every index is in range.
    assign payload_ext = {BYTE_W'(0), payload};
    assign pos         = byte_pos(MSB_FIRST, nbytes, idx);
    assign byte_sel    = payload_ext[{pos, 3'b000} +: BYTE_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            payload    <= '0;
            nbytes     <= '0;
            idx        <= '0;
            bytes_sent <= '0;
            tx_data_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_LATCH) begin
                payload <= fifo_dout[PAYLOAD_W-1:0];
                nbytes  <= fifo_dout[N_MSB:N_LSB];
                idx     <= '0;
            end else if (tx_start) begin
                idx        <= idx + BYTE_CNT_W'(1);
                bytes_sent <= bytes_sent + SENT_W'(1);
                tx_data_q  <= byte_sel;
            end
        end
    end

    // tx_data shows the selected byte during the start pulse and holds it after.
    always_comb begin
        state_nxt = state;
        fifo_rden = 1'b0;
        tx_start  = 1'b0;
        tx_data   = tx_data_q;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (enable && !fifo_empty) begin
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                fifo_rden = 1'b1;
                state_nxt = S_LATCH;
            end
            S_LATCH: begin
                state_nxt = (fifo_dout[N_MSB:N_LSB] == '0) ? S_IDLE : S_SEND;
            end
            S_SEND: begin
                if (!tx_busy) begin
                    tx_start  = 1'b1;
                    tx_data   = byte_sel;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                state_nxt = (idx < nbytes) ? S_SEND : S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench: LSB-first and MSB-first instances run in lockstep
// against a FIFO model, a busy-hold transmitter model and a byte-stream model.
module tb_uart_tx_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        fifo_empty;
    logic [31:0] fifo_dout;
    logic        tx_busy;

    logic        rden0, rden1, start0, start1, busy0, busy1;
    logic [7:0]  data0, data1;
    logic [15:0] sent0, sent1;

    always #5 clk = ~clk;

    uart_tx_sched #(.MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout), .fifo_rden(rden0), .tx_busy(tx_busy),
        .tx_start(start0), .tx_data(data0), .busy(busy0), .bytes_sent(sent0)
    );

    uart_tx_sched #(.MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout), .fifo_rden(rden1), .tx_busy(tx_busy),
        .tx_start(start1), .tx_data(data1), .busy(busy1), .bytes_sent(sent1)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Environment state shared between the model process and the test
    logic [31:0] q[$];
    logic [7:0]  cap0[$], cap1[$];
    logic [7:0]  exp0[$], exp1[$];
    int          start_cyc[$];
    int          cyc = 0, rden_cyc = 0, rd_count = 0;
    int          blen = 0, busy_left = 0, arm_len = 0;
    bit          arm = 1'b0, pend_v = 1'b0, rand_en = 1'b0;
    logic [31:0] pend;
    logic [15:0] sent_model;
    int          words_pushed = 0;

    // FIFO, transmitter and monitor model: sample at negedge, drive just after posedge
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            chk("lockstep_start", 32'(start1), 32'(start0));
            chk("lockstep_rden", 32'(rden1), 32'(rden0));
            if (start0) begin
                cap0.push_back(data0);
                start_cyc.push_back(cyc);
                chk("start_while_busy", 32'(tx_busy), 32'(0));
                if (blen > 0) begin
                    arm     = 1'b1;
                    arm_len = blen;
                end
            end
            if (start1) cap1.push_back(data1);
            if (rden0) begin
                rd_count++;
                rden_cyc = cyc;
                chk("rden_fifo_nonempty", 32'(q.size() != 0), 32'(1));
                if (q.size() != 0) begin
                    pend   = q.pop_front();
                    pend_v = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            if (pend_v) begin
                fifo_dout = pend;
                pend_v    = 1'b0;
            end
            fifo_empty = (q.size() == 0);
            if (arm) begin
                tx_busy   = 1'b1;
                busy_left = arm_len;
                arm       = 1'b0;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) tx_busy = 1'b0;
            end
            if (rand_en) enable = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    function automatic logic [7:0] qget(input logic [7:0] qq[$], input int i);
        if (i < qq.size()) return qq[i];
        return 8'bx;
    endfunction

    // Byte-stream model: N from bits 25:24, bytes taken as plain shifts of the word
    task automatic push_word(input logic [31:0] w);
        int n;
        n = int'(w[25:24]);
        q.push_back(w);
        for (int k = 0; k < n; k++) exp0.push_back(8'((w >> (8 * k)) & 32'hff));
        for (int k = n - 1; k >= 0; k--) exp1.push_back(8'((w >> (8 * k)) & 32'hff));
        sent_model = sent_model + 16'(n);
        words_pushed++;
    endtask

    task automatic clear_caps();
        cap0.delete();
        cap1.delete();
        exp0.delete();
        exp1.delete();
        start_cyc.delete();
    endtask

    task automatic wait_idle(input int maxc, input string tag);
        bit done;
        done = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < maxc; i++) begin
            if (q.size() == 0 && !busy0 && !tx_busy && !arm && !pend_v) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        chk({tag, "_done"}, 32'(done), 32'(1));
    endtask

    typedef struct {
        logic [31:0] word;
        int          blen;
        int          n;
        logic [23:0] exp_lsb;   // send order, first byte in [7:0]
        logic [23:0] exp_msb;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int rdc0;
        int gap;
        vec_t v;

        vecs[0] = '{32'h03abcdef, 0,  3, 24'habcdef, 24'hefcdab};
        vecs[1] = '{32'h0cabcdef, 0,  0, 24'h000000, 24'h000000};
        vecs[2] = '{32'h02abcdef, 10, 2, 24'h00cdef, 24'h00efcd};
        vecs[3] = '{32'h01123456, 2,  1, 24'h000056, 24'h000056};
        vecs[4] = '{32'hff000080, 1,  3, 24'h000080, 24'h800000};
        vecs[5] = '{32'h0e5a1234, 0,  2, 24'h001234, 24'h003412};

        rst        = 1'b1;
        enable     = 1'b0;
        fifo_empty = 1'b1;
        fifo_dout  = '0;
        tx_busy    = 1'b0;
        sent_model = '0;
        repeat (3) tick();

        chk("rst_rden", 32'(rden0), 32'(0));
        chk("rst_start", 32'(start0), 32'(0));
        chk("rst_data", 32'(data0), 32'(0));
        chk("rst_busy", 32'(busy0), 32'(0));
        chk("rst_sent", 32'(sent0), 32'(0));

        // no fetch while reset is held, even with work pending
        enable = 1'b1;
        push_word(32'h01000055);
        repeat (4) tick();
        chk("no_fetch_in_reset", 32'(rd_count), 32'(0));
        rst = 1'b0;
        wait_idle(50, "first");
        chk("first_byte", 32'(qget(cap0, 0)), 32'h55);
        chk("first_sent", 32'(sent0), 32'(sent_model));

        foreach (vecs[vi]) begin
            v = vecs[vi];
            clear_caps();
            rdc0 = rd_count;
            blen = v.blen;
            push_word(v.word);
            wait_idle(200, "vec");
            chk("vec_count_lsb", 32'(cap0.size()), 32'(v.n));
            chk("vec_count_msb", 32'(cap1.size()), 32'(v.n));
            for (int i = 0; i < v.n; i++) begin
                chk("vec_byte_lsb", 32'(qget(cap0, i)), 32'(v.exp_lsb[8*i +: 8]));
                chk("vec_byte_msb", 32'(qget(cap1, i)), 32'(v.exp_msb[8*i +: 8]));
            end
            chk("vec_one_fetch", 32'(rd_count - rdc0), 32'(1));
            chk("vec_sent0", 32'(sent0), 32'(sent_model));
            chk("vec_sent1", 32'(sent1), 32'(sent_model));
            chk("vec_busy_end", 32'(busy0), 32'(0));
            if (v.n > 0) chk("lat_first", 32'(start_cyc[0] - rden_cyc), 32'(2));
            gap = (v.blen + 1 > 2) ? v.blen + 1 : 2;
            for (int i = 1; i < v.n && i < start_cyc.size(); i++)
                chk("lat_gap", 32'(start_cyc[i] - start_cyc[i-1]), 32'(gap));
        end

        // enable dropped right after the first fetch: current word completes, next waits
        blen = 0;
        clear_caps();
        rdc0 = rd_count;
        push_word(32'h01000011);
        push_word(32'h01000022);
        for (int i = 0; i < 50 && rd_count == rdc0; i++) tick();
        enable = 1'b0;
        repeat (40) tick();
        chk("hold_fetches", 32'(rd_count - rdc0), 32'(1));
        chk("hold_count", 32'(cap0.size()), 32'(1));
        chk("hold_byte", 32'(qget(cap0, 0)), 32'h11);
        chk("hold_busy", 32'(busy0), 32'(0));
        enable = 1'b1;
        wait_idle(50, "resume");
        chk("resume_fetches", 32'(rd_count - rdc0), 32'(2));
        chk("resume_byte", 32'(qget(cap0, 1)), 32'h22);

        // reset in WAIT after the first byte of a 3-byte word
        clear_caps();
        push_word(32'h03112233);
        for (int i = 0; i < 50 && cap0.size() == 0; i++) tick();
        chk("pre_rst_byte", 32'(qget(cap0, 0)), 32'h33);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_rden", 32'(rden0), 32'(0));
        chk("mid_rst_start", 32'(start0), 32'(0));
        chk("mid_rst_data", 32'(data0), 32'(0));
        chk("mid_rst_data_msb", 32'(data1), 32'(0));
        chk("mid_rst_busy", 32'(busy0), 32'(0));
        chk("mid_rst_sent", 32'(sent0), 32'(0));
        sent_model = '0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (20) tick();
        chk("post_rst_no_tx", 32'(cap0.size()), 32'(1));
        chk("post_rst_sent", 32'(sent0), 32'(0));

        // counter wrap from a preloaded value
        tick();
        force dut0.bytes_sent = 16'hfffe;
        force dut1.bytes_sent = 16'hfffe;
        #1;
        release dut0.bytes_sent;
        release dut1.bytes_sent;
        #1;
        chk("preload", 32'(sent0), 32'hfffe);
        sent_model = 16'hfffe;
        clear_caps();
        push_word(32'h03000000);
        wait_idle(50, "wrap");
        chk("wrap_sent0", 32'(sent0), 32'h0001);
        chk("wrap_sent1", 32'(sent1), 32'(sent_model));

        // randomized words, busy lengths and enable toggling
        clear_caps();
        rdc0 = words_pushed;
        rand_en = 1'b1;
        for (int b = 0; b < 60; b++) begin
            blen = $urandom_range(0, 3);
            repeat ($urandom_range(1, 3)) push_word($urandom);
            repeat ($urandom_range(0, 12)) tick();
        end
        rand_en = 1'b0;
        enable  = 1'b1;
        wait_idle(4000, "rand");
        chk("rand_count_lsb", 32'(cap0.size()), 32'(exp0.size()));
        chk("rand_count_msb", 32'(cap1.size()), 32'(exp1.size()));
        for (int i = 0; i < exp0.size(); i++) begin
            chk("rand_byte_lsb", 32'(qget(cap0, i)), 32'(exp0[i]));
            chk("rand_byte_msb", 32'(qget(cap1, i)), 32'(exp1[i]));
        end
        chk("rand_sent", 32'(sent0), 32'(sent_model));
        chk("rand_busy_end", 32'(busy0), 32'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter: MSB_FIRST, default 0, byte order (0: payload bits [7:0] sent first; 1: highest valid byte sent first).
REQ-002 clk  input  1  single system clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 enable  input  1  permit fetching new words from the TX FIFO.
REQ-005 fifo_empty  input  1  TX word FIFO empty flag.
REQ-006 fifo_dout  input  32  TX FIFO read data, valid the cycle after fifo_rden.
REQ-007 fifo_rden  output  1  one-cycle FIFO read pulse.
REQ-008 tx_busy  input  1  UART transmitter busy; rises the cycle after tx_start.
REQ-009 tx_start  output  1  one-cycle pulse, tx_data valid in the same cycle.
REQ-010 tx_data  output  8  byte to transmit.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 bytes_sent  output  16  count of tx_start pulses since reset.

Function
REQ-013 Word format: [25:24] = byte count N (0..3); [23:0] = payload; [31:26] ignored.
REQ-014 States: IDLE, READ, LATCH, SEND, WAIT.
REQ-015 IDLE -> READ when enable=1 and fifo_empty=0; otherwise stay.
REQ-016 READ: fifo_rden=1 for exactly this cycle; -> LATCH unconditionally.
REQ-017 LATCH: register fifo_dout payload and N, clear byte index; N=0 -> IDLE (word discarded, no tx_start); else -> SEND.
REQ-018 SEND: if tx_busy=0, assert tx_start with the byte at the current index, increment index and bytes_sent, -> WAIT; if tx_busy=1, hold with tx_start=0.
REQ-019 WAIT: one cycle, tx_busy ignored; -> SEND if bytes remain, else -> IDLE.
REQ-020 Byte order MSB_FIRST=0: [7:0], [15:8], [23:16], truncated to N bytes; MSB_FIRST=1: byte N-1 down to byte 0.
REQ-021 Latency: with tx_busy=0, first tx_start occurs 2 cycles after the fifo_rden cycle; successive bytes of one word are spaced by at least 2 cycles plus the tx_busy duration.
REQ-022 fifo_rden never asserts outside READ; at most one word is held in flight.
REQ-023 enable deasserted mid-word: the current word completes; no further fetch until enable=1.
REQ-024 fifo_empty asserted after READ has no effect on the word being latched.
REQ-025 tx_data holds its last value between pulses.
REQ-026 bytes_sent wraps 0xFFFF -> 0x0000 without saturation or flag.

Reset
REQ-027 rst asserted, at any time and in any state, immediately forces state=IDLE, fifo_rden=0, tx_start=0, tx_data=0x00, busy=0, bytes_sent=0, byte index=0; a partially sent word is lost.
REQ-028 First fetch occurs no earlier than the first rising edge after rst deasserts.

Structure
REQ-029 Package uart_sched_pkg holds the state enum, the N field position (25:24), payload width (24), and byte-count width (2).
REQ-030 Single flat module, no sub-module; byte selection is an indexed mux inside uart_tx_sched.

Verification
REQ-031 FIFO word 0x03abcdef, MSB_FIRST=0, tx_busy low -> one fifo_rden; tx_data ef, cd, ab on three tx_start pulses; bytes_sent=3; busy=0 after the last WAIT.
REQ-032 Word 0x0cabcdef (N=0) -> fifo_rden pulses once, no tx_start, return to IDLE; bytes_sent unchanged.
REQ-033 Word 0x02abcdef, MSB_FIRST=1, tx_busy held high 10 cycles after each start -> tx_data cd then ef; no tx_start while tx_busy=1.
REQ-034 Two queued words; enable dropped after the first fifo_rden -> first word fully sent, second not fetched until enable returns.
REQ-035 rst asserted in WAIT after byte 1 of 0x03112233 -> all outputs at reset values within the same cycle; after release with the FIFO empty, no tx_start.
REQ-036 Preload bytes_sent near wrap (0xFFFE, via 65534 single-byte words or a force) then one 0x03000000 word -> count reads 0x0001.
